// File: rtl/wb_regfile.sv
// Writeback stage: result mux, 15-entry register file with write-first read bypass,
// PC-redirect handshake toward fetch, and a retire counter.
module wb_regfile #(
  parameter int WIDTH = 32,
  parameter int NREGS = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             PCSrcW,
  input  logic             RegWriteW,
  input  logic             MemtoRegW,
  input  logic [3:0]       WA3W,
  input  logic [WIDTH-1:0] ReadDataW,
  input  logic [WIDTH-1:0] ALUOutW,
  input  logic [3:0]       RA1D,
  input  logic [3:0]       RA2D,
  input  logic [WIDTH-1:0] PCPlus8D,
  input  logic             RedirAck,
  output logic [WIDTH-1:0] RD1D,
  output logic [WIDTH-1:0] RD2D,
  output logic [WIDTH-1:0] ResultW,
  output logic             RedirValid,
  output logic [WIDTH-1:0] RedirPC,
  output logic [31:0]      RetireCount
);

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];
  logic             redir_valid_q, redir_valid_d;
  logic [WIDTH-1:0] redir_pc_q, redir_pc_d;
  logic [31:0]      retire_q, retire_d;

  assign ResultW = MemtoRegW ? ReadDataW : ALUOutW;

  // Index compare loop keeps R15 (the PC) from ever addressing the array.
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      regs_d[i] = regs_q[i];
      if (RegWriteW && (WA3W == 4'(i))) regs_d[i] = ResultW;
    end
  end

  always_comb begin
    redir_valid_d = redir_valid_q;
    redir_pc_d    = redir_pc_q;
    retire_d      = retire_q;
    if (PCSrcW) begin
      redir_valid_d = 1'b1;
      redir_pc_d    = ResultW;
    end else if (RedirAck) begin
      redir_valid_d = 1'b0;
    end
    if (RegWriteW || PCSrcW) retire_d = retire_q + 32'd1;
  end

  // Read ports: PC slot has priority, then same-cycle write bypass, then the array.
  always_comb begin
    RD1D = '0;
    RD2D = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (RA1D == 4'(i)) RD1D = regs_q[i];
      if (RA2D == 4'(i)) RD2D = regs_q[i];
    end
    if (RegWriteW && (WA3W == RA1D)) RD1D = ResultW;
    if (RegWriteW && (WA3W == RA2D)) RD2D = ResultW;
    if (RA1D == 4'hF) RD1D = PCPlus8D;
    if (RA2D == 4'hF) RD2D = PCPlus8D;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      redir_valid_q <= 1'b0;
      redir_pc_q    <= '0;
      retire_q      <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
      redir_valid_q <= redir_valid_d;
      redir_pc_q    <= redir_pc_d;
      retire_q      <= retire_d;
    end
  end

  assign RedirValid  = redir_valid_q;
  assign RedirPC     = redir_pc_q;
  assign RetireCount = retire_q;

endmodule
